// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble serial adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-word adder: latches operands, adds one nibble per cycle LSB first
// with a registered ripple carry, then holds the result until consumed.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  nibble_serial_adder_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             c_out_reg;
  logic             ovf_reg;
  logic [4:0]       nib_sum;
  logic [3:0]       low3_sum;
  logic             idx_valid;
  logic             idx_last;

  // Current nibble add; operands are shifted right each step so the active
  // nibble is always at [3:0]. low3_sum[3] is the carry into the nibble MSB.
  always_comb begin
    nib_sum   = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0, carry};
    low3_sum  = {1'b0, a_reg[2:0]} + {1'b0, b_reg[2:0]} + {3'b0, carry};
    idx_valid = (32'(idx) < NIBBLES);
    idx_last  = (32'(idx) == NIBBLES - 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = RUN;
      RUN: begin
        if (!idx_valid)    state_next = IDLE;
        else if (idx_last) state_next = DONE;
      end
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: handshake flags from state, results from registers.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.sum       = sum_reg;
    bus.c_out     = c_out_reg;
    bus.overflow  = ovf_reg;
  end

  // Datapath: operand capture, per-nibble sum write-back and carry ripple.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          if (idx_valid) begin
            sum_reg[{idx, 2'b00} +: 4] <= nib_sum[3:0];
            carry <= nib_sum[4];
            a_reg <= a_reg >> 4;
            b_reg <= b_reg >> 4;
            idx   <= idx + 1'b1;
            if (idx_last) begin
              c_out_reg <= nib_sum[4];
              ovf_reg   <= low3_sum[3] ^ nib_sum[4];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
